// File: rtl/vram_slot_arbiter_pkg.sv
// Shared phase encoding and screen wrap constants for the VRAM slot arbiter.
// The wrap addition is only applied in builds with VIDEO_WRAP_EN defined.
package vram_slot_arbiter_pkg;

  typedef enum logic [1:0] {
    PH_CPU_ADR = 2'd0,
    PH_CPU_ACC = 2'd1,
    PH_VID_ADR = 2'd2,
    PH_VID_ACC = 2'd3
  } phase_e;

  localparam logic [14:0] WRAP_SS0 = 15'h4000;
  localparam logic [14:0] WRAP_SS1 = 15'h6000;
  localparam logic [14:0] WRAP_SS2 = 15'h3000;
  localparam logic [14:0] WRAP_SS3 = 15'h5800;

  localparam logic [4:0] TTX_BASE = 5'b11111;

  function automatic logic [14:0] wrap_const(input logic [1:0] ss);
    logic [14:0] w;
    unique case (ss)
      2'd0:    w = WRAP_SS0;
      2'd1:    w = WRAP_SS1;
      2'd2:    w = WRAP_SS2;
      default: w = WRAP_SS3;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/video_addr_map.sv
// CRTC MA/RA to physical RAM address, graphics and teletext modes.
// VIDEO_WRAP_EN enables the screen_size wrap addition for MA[12] addresses.
module video_addr_map
  import vram_slot_arbiter_pkg::*;
(
  input  logic [13:0] framestore_adr_i,
  input  logic [4:0]  scanline_row_i,
  input  logic [1:0]  screen_size_i,
  input  logic        teletext_i,
  output logic [14:0] adr_o
);

  logic [14:0] raw;
  logic [14:0] gfx;
  logic        unused_bits;

  assign raw = {framestore_adr_i[11:0], scanline_row_i[2:0]};

  assign unused_bits = ^{framestore_adr_i[13], scanline_row_i[4:3],
                         screen_size_i};

  always_comb begin
    gfx = raw;
`ifdef VIDEO_WRAP_EN
    // 15-bit sum drops the carry, giving the modulo-32K wrap
    if (framestore_adr_i[12]) begin
      gfx = raw + wrap_const(screen_size_i);
    end
`endif
  end

  assign adr_o = teletext_i ? {TTX_BASE, framestore_adr_i[9:0]} : gfx;

endmodule

// File: rtl/vram_slot_arbiter.sv
// Four-phase CPU/video time-division arbiter for the shared screen RAM.
// Video address wrap is controlled by VIDEO_WRAP_EN (see video_addr_map).
module vram_slot_arbiter
  import vram_slot_arbiter_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic        PIXELCLK,
  input  logic        RESET,
  input  logic        cpu_sel,
  input  logic        cpu_rnw,
  input  logic [14:0] cpu_adr,
  input  logic [7:0]  cpu_wdata,
  input  logic [13:0] framestore_adr,
  input  logic [4:0]  scanline_row,
  input  logic [1:0]  screen_size,
  input  logic        teletext,
  input  logic [7:0]  ram_rdata,
  output logic [14:0] ram_adr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        ram_oe,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  output logic        PROC_en,
  output logic        CRTC_en,
  output logic        PHI_2
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  phase_e      phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [14:0] ram_adr_q, ram_adr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        sel_q, sel_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic        vid_valid_q, vid_valid_d;

  logic        first;
  logic        last;
  logic [14:0] vid_adr;

  video_addr_map u_map (
    .framestore_adr_i (framestore_adr),
    .scanline_row_i   (scanline_row),
    .screen_size_i    (screen_size),
    .teletext_i       (teletext),
    .adr_o            (vid_adr)
  );

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == LAST);

  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q + CW'(1);
    ram_adr_d   = ram_adr_q;
    ram_wdata_d = ram_wdata_q;
    sel_d       = sel_q;
    rnw_d       = rnw_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_data_q;
    ram_we      = 1'b0;
    ram_oe      = 1'b0;
    PROC_en     = 1'b0;
    CRTC_en     = 1'b0;
    PHI_2       = 1'b0;

    if (last) begin
      cnt_d   = '0;
      phase_d = phase_e'(phase_q + 2'd1);
    end

    unique case (phase_q)
      PH_CPU_ADR: begin
        if (first) begin
          ram_adr_d   = cpu_adr;
          ram_wdata_d = cpu_wdata;
          sel_d       = cpu_sel;
          rnw_d       = cpu_rnw;
        end
      end
      PH_CPU_ACC: begin
        PHI_2  = 1'b1;
        ram_we = sel_q & ~rnw_q;
        ram_oe = sel_q & rnw_q;
        if (last) begin
          PROC_en = 1'b1;
          if (sel_q & rnw_q) cpu_rdata_d = ram_rdata;
        end
      end
      PH_VID_ADR: begin
        ram_oe = 1'b1;
        if (first) ram_adr_d = vid_adr;
      end
      PH_VID_ACC: begin
        ram_oe = 1'b1;
        if (last) begin
          CRTC_en    = 1'b1;
          vid_data_d = ram_rdata;
        end
      end
      default: ;
    endcase

    vid_valid_d = CRTC_en;
  end

  // Reset drops the slot back to CPU_ADR so any write strobe ends at once
  always_ff @(posedge PIXELCLK) begin
    if (RESET) begin
      phase_q     <= PH_CPU_ADR;
      cnt_q       <= '0;
      ram_adr_q   <= '0;
      ram_wdata_q <= '0;
      sel_q       <= 1'b0;
      rnw_q       <= 1'b0;
      cpu_rdata_q <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      ram_adr_q   <= ram_adr_d;
      ram_wdata_q <= ram_wdata_d;
      sel_q       <= sel_d;
      rnw_q       <= rnw_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  assign ram_adr   = ram_adr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Scoreboard bench for vram_slot_arbiter: random slots against a RAM model.
// Honours VIDEO_WRAP_EN the same way as the design build.
module tb_vram_slot_arbiter;

  localparam int H  = 2;
  localparam int P  = 4 * H;
  localparam int NS = 300;
`ifdef VIDEO_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        PIXELCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        cpu_sel = 1'b0;
  logic        cpu_rnw = 1'b1;
  logic [14:0] cpu_adr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [13:0] framestore_adr = '0;
  logic [4:0]  scanline_row = '0;
  logic [1:0]  screen_size = '0;
  logic        teletext = 1'b0;
  logic [7:0]  ram_rdata;
  logic [14:0] ram_adr;
  logic [7:0]  ram_wdata;
  logic        ram_we, ram_oe;
  logic [7:0]  cpu_rdata, vid_data;
  logic        vid_valid, PROC_en, CRTC_en, PHI_2;

  vram_slot_arbiter #(.HALF(H)) dut (
    .PIXELCLK(PIXELCLK), .RESET(RESET),
    .cpu_sel(cpu_sel), .cpu_rnw(cpu_rnw),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .framestore_adr(framestore_adr),
    .scanline_row(scanline_row),
    .screen_size(screen_size), .teletext(teletext),
    .ram_rdata(ram_rdata), .ram_adr(ram_adr),
    .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_oe(ram_oe), .cpu_rdata(cpu_rdata),
    .vid_data(vid_data), .vid_valid(vid_valid),
    .PROC_en(PROC_en), .CRTC_en(CRTC_en),
    .PHI_2(PHI_2)
  );

  always #5 PIXELCLK = ~PIXELCLK;

  logic [7:0] mem [0:32767];
  logic [7:0] ref_mem [0:32767];

  always @(posedge PIXELCLK) if (ram_we === 1'b1) mem[ram_adr] <= ram_wdata;
  assign ram_rdata = mem[ram_adr];

  int pos = 0;
  always @(posedge PIXELCLK) pos <= RESET ? 0 : (pos == P - 1 ? 0 : pos + 1);

  int tests = 0;
  int fails = 0;

  logic [7:0]  cpu_q [$];
  logic [7:0]  vid_q [$];
  logic [14:0] vadr_q [$];

  bit          cur_wr = 0, cur_rd = 0;
  logic [14:0] cur_adr = '0;
  logic [7:0]  cur_wd = '0;
  logic [7:0]  last_rd = '0;
  bit          mon_en = 0;
  bit          chk_cpu = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic miss(input string n);
    tests++;
    fails++;
    $display("FAIL %s: got DUT output expected none queued at %0t", n, $time);
  endtask

  function automatic logic [14:0] vaddr(input int fs, input int row,
                                        input int ss, input bit tt);
    int a;
    int w;
    if (tt) return 15'(32'h7C00 + fs % 1024);
    a = (fs % 4096) * 8 + row % 8;
    w = (ss == 0) ? 'h4000 : (ss == 1) ? 'h6000 :
        (ss == 2) ? 'h3000 : 'h5800;
    if (WRAP_EN && (fs / 4096) % 2 == 1) a = a + w;
    return 15'(a % 32768);
  endfunction

  always @(negedge PIXELCLK) begin
    if (mon_en) begin
      chk("proc_en", 32'(PROC_en), 32'(pos == 2 * H - 1));
      chk("crtc_en", 32'(CRTC_en), 32'(pos == P - 1));
      chk("phi_2", 32'(PHI_2), 32'(pos >= H && pos < 2 * H));
      chk("ram_we", 32'(ram_we), 32'(pos >= H && pos < 2 * H && cur_wr));
      chk("ram_oe", 32'(ram_oe),
          32'(pos < H ? 1'b0 : pos < 2 * H ? cur_rd : 1'b1));
      if (pos >= 1 && pos <= 2 * H)
        chk("cpu_ram_adr", 32'(ram_adr), 32'(cur_adr));
      if (pos >= H && pos < 2 * H && cur_wr)
        chk("ram_wdata", 32'(ram_wdata), 32'(cur_wd));
      if (pos == 2 * H + 1) begin
        if (vadr_q.size() == 0) miss("vid_ram_adr");
        else chk("vid_ram_adr", 32'(ram_adr), 32'(vadr_q.pop_front()));
      end
      if (chk_cpu) begin
        chk_cpu = 0;
        if (cpu_q.size() == 0) miss("cpu_rdata");
        else chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
      end
      if (PROC_en) chk_cpu = 1;
      if (vid_valid) begin
        chk("vid_valid_pos", 32'(pos), 32'(0));
        if (vid_q.size() == 0) miss("vid_data");
        else chk("vid_data", 32'(vid_data), 32'(vid_q.pop_front()));
      end
    end
  end

  task automatic issue_cpu(input int s);
    bit sel, rnw;
    logic [14:0] a;
    logic [7:0] d;
    sel = ($urandom_range(0, 3) != 0);
    rnw = $urandom_range(0, 1);
    a   = 15'($urandom_range(0, 32767));
    d   = 8'($urandom_range(0, 255));
    if (s == 0) begin sel = 1; rnw = 0; a = 15'h1234; d = 8'hA5; end
    if (s == 1) begin sel = 1; rnw = 1; a = 15'h1234; end
    if (s == 2) sel = 0;
    if (s == 3) begin sel = 1; rnw = 0; end
    cpu_sel = sel; cpu_rnw = rnw; cpu_adr = a; cpu_wdata = d;
    cur_adr = a; cur_wd = d;
    cur_wr = sel && !rnw;
    cur_rd = sel && rnw;
    if (cur_wr) ref_mem[a] = d;
    if (cur_rd) last_rd = ref_mem[a];
    cpu_q.push_back(last_rd);
  endtask

  task automatic issue_vid(input int s);
    int fs, row, ss;
    bit tt;
    logic [14:0] va;
    fs  = $urandom_range(0, 16383);
    row = $urandom_range(0, 31);
    ss  = $urandom_range(0, 3);
    tt  = ($urandom_range(0, 3) == 0);
    if (s == 0) begin fs = 'h1000; row = 3; ss = 1; tt = 0; end
    if (s == 1) begin fs = 'h3FF; row = 7; tt = 1; end
    framestore_adr = 14'(fs); scanline_row = 5'(row);
    screen_size = 2'(ss); teletext = tt;
    va = vaddr(fs, row, ss, tt);
    vadr_q.push_back(va);
    vid_q.push_back(ref_mem[va]);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge PIXELCLK);
    #1;
    RESET = 1'b0;
    chk("rst_ram_adr", 32'(ram_adr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_oe", 32'(ram_oe), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_vid_data", 32'(vid_data), 0);
    chk("rst_vid_valid", 32'(vid_valid), 0);
    chk("rst_proc_en", 32'(PROC_en), 0);
    chk("rst_crtc_en", 32'(CRTC_en), 0);
    chk("rst_phi_2", 32'(PHI_2), 0);
    mon_en = 1;
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < P; p++) begin
        if (p > 0) begin @(posedge PIXELCLK); #1; end
        if (p != 0) begin
          cpu_sel   = (s == 2) ? 1'b1 : 1'($urandom_range(0, 1));
          cpu_rnw   = 1'($urandom_range(0, 1));
          cpu_adr   = 15'($urandom_range(0, 32767));
          cpu_wdata = 8'($urandom_range(0, 255));
        end
        if (p != 2 * H) begin
          framestore_adr = 14'($urandom_range(0, 16383));
          scanline_row   = 5'($urandom_range(0, 31));
          screen_size    = 2'($urandom_range(0, 3));
          teletext       = 1'($urandom_range(0, 1));
        end
        if (p == 0) issue_cpu(s);
        if (p == 2 * H) issue_vid(s);
        if (s == 0 && p == H) begin
          chk("dir_we", 32'(ram_we), 1);
          chk("dir_we_adr", 32'(ram_adr), 32'h1234);
        end
        if (s == 0 && p == 2 * H + 1)
          chk("dir_vadr_wrap", 32'(ram_adr), WRAP_EN ? 32'h6003 : 32'h0003);
        if (s == 1 && p == 2 * H)
          chk("dir_readback", 32'(cpu_rdata), 32'hA5);
        if (s == 1 && p == 2 * H + 1)
          chk("dir_vadr_ttx", 32'(ram_adr), 32'h7FFF);
        if (s == 2 && p == H)
          chk("dir_late_sel_oe", 32'(ram_oe), 0);
        if (s == 3 && p == H) begin
          RESET = 1'b1;
          break;
        end
      end
      @(posedge PIXELCLK);
      #1;
      if (RESET) begin
        RESET = 1'b0;
        cpu_q.delete();
        cur_wr = 0;
        cur_rd = 0;
        last_rd = '0;
        chk("abort_we", 32'(ram_we), 0);
        chk("abort_cpu_rdata", 32'(cpu_rdata), 0);
      end
    end
    @(negedge PIXELCLK);
    #1;
    mon_en = 0;
    chk("drain", 32'(vid_q.size() + cpu_q.size() + vadr_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
